// File: rtl/dense_requant_pkg.sv
// rtl/dense_requant_pkg.sv - shared state encoding and widths for the dense requant serializer
package dense_requant_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_QUANT = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    localparam int ACC_W = 34;
    localparam int PIX_W = 8;

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane round/shift/clamp, ACC_W -> PIX_W; DENSE_REQUANT_RELU_EN selects unsigned clamp
module requant_lane
    import dense_requant_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input  logic [ACC_W-1:0] i_acc,
    output logic [PIX_W-1:0] o_pix
);

    logic signed [ACC_W-1:0] w_r;

    generate
        if (SHIFT > 0) begin : g_round
            // Adding half an LSB before the arithmetic shift gives round-half-up.
            localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0);
            logic signed [ACC_W-1:0] w_sum;
            assign w_sum = $signed(i_acc) + RND;
            assign w_r   = w_sum >>> SHIFT;
        end else begin : g_pass
            assign w_r = $signed(i_acc);
        end
    endgenerate

`ifdef DENSE_REQUANT_RELU_EN
    localparam logic signed [ACC_W-1:0] LO = '0;
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(255);

    always_comb begin
        o_pix = w_r[PIX_W-1:0];
        if (w_r < LO) begin
            o_pix = 8'h00;
        end else if (w_r > HI) begin
            o_pix = 8'hff;
        end
    end
`else
    localparam logic signed [ACC_W-1:0] LO = -ACC_W'(128);
    localparam logic signed [ACC_W-1:0] HI = ACC_W'(127);

    always_comb begin
        o_pix = w_r[PIX_W-1:0];
        if (w_r < LO) begin
            o_pix = 8'h80;
        end else if (w_r > HI) begin
            o_pix = 8'h7f;
        end
    end
`endif

endmodule

// File: rtl/dense_requant_serializer.sv
// rtl/dense_requant_serializer.sv - bias add, requantize and byte-serialize NUM_TREES lanes; option DENSE_REQUANT_RELU_EN
module dense_requant_serializer
    import dense_requant_pkg::*;
#(
    parameter int NUM_TREES = 2,
    parameter int SHIFT     = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [32*NUM_TREES-1:0]   pixel_in,
    input  logic [32*NUM_TREES-1:0]   bias,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [PIX_W-1:0]          pixel_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last
);

    localparam int IDX_W = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TREES - 1);

    logic [1:0]                        r_state;
    logic [1:0]                        w_next_state;
    logic [IDX_W-1:0]                  r_idx;
    logic [NUM_TREES-1:0][ACC_W-1:0]   r_acc;
    logic [NUM_TREES-1:0][PIX_W-1:0]   r_bank;
    logic [NUM_TREES-1:0][PIX_W-1:0]   w_quant;
    logic                              w_accept;
    logic                              w_send_hs;
    logic                              w_last;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_send_hs = (r_state == ST_SEND) && out_ready;

    generate
        for (genvar g = 0; g < NUM_TREES; g++) begin : g_lane
            requant_lane #(.SHIFT(SHIFT)) u_lane (
                .i_acc (r_acc[g]),
                .o_pix (w_quant[g])
            );
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_QUANT;
            ST_QUANT: w_next_state = ST_SEND;
            ST_SEND:  if (out_ready && w_last) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are gated by reset so nothing leaks out while a vector is being aborted.
    always_comb begin
        in_ready  = !reset && (r_state == ST_IDLE);
        out_valid = !reset && (r_state == ST_SEND);
        out_last  = out_valid && w_last;
        pixel_out = out_valid ? r_bank[r_idx] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc  <= '0;
            r_bank <= '0;
            r_idx  <= '0;
        end else begin
            if (w_accept) begin
                for (int k = 0; k < NUM_TREES; k++) begin
                    r_acc[k] <= {{(ACC_W-32){pixel_in[32*k+31]}}, pixel_in[32*k +: 32]}
                              + {{(ACC_W-32){bias[32*k+31]}}, bias[32*k +: 32]};
                end
            end
            if (r_state == ST_QUANT) begin
                r_bank <= w_quant;
                r_idx  <= '0;
            end
            if (w_send_hs) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dense_requant_serializer.sv
// tb/tb_dense_requant_serializer.sv - randomized self-checking bench against an arithmetic reference model
module tb_dense_requant_serializer;

    localparam int NT    = 2;
    localparam int SHIFT = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [32*NT-1:0]  pixel_in;
    logic [32*NT-1:0]  bias;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        pixel_out;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    int n_checks = 0;
    int n_errors = 0;

    dense_requant_serializer #(.NUM_TREES(NT), .SHIFT(SHIFT)) dut (
        .clock     (clock),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .bias      (bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixel_out (pixel_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    // Reference: exact integer math, round half up, then clamp to the configured byte range.
    function automatic logic [7:0] model_q(input longint px, input longint b);
        longint a;
        longint r;
        logic [63:0] rv;
        a = px + b;
        if (SHIFT > 0) r = floor_div(a + (longint'(1) << (SHIFT - 1)), longint'(1) << SHIFT);
        else           r = a;
`ifdef DENSE_REQUANT_RELU_EN
        if (r < 0)   r = 0;
        if (r > 255) r = 255;
`else
        if (r < -128) r = -128;
        if (r > 127)  r = 127;
`endif
        rv = r;
        return rv[7:0];
    endfunction

    // stall0: cycles to hold out_ready low on the first byte; rnd: random out_ready afterwards.
    task automatic run_vec(input int p0, input int p1, input int b0, input int b1,
                           input int stall0, input bit rnd, input bit keep_valid);
        logic [7:0] exp_q[$];
        int i;
        int guard;
        int stalls;
        bit rdy;
        exp_q.delete();
        exp_q.push_back(model_q(longint'(p0), longint'(b0)));
        exp_q.push_back(model_q(longint'(p1), longint'(b1)));
        pixel_in = {p1, p0};
        bias     = {b1, b0};
        in_valid = 1'b1;
        out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        chk("accept_ready", in_ready, 1);
        @(negedge clock);
        chk("quant_valid", out_valid, 0);
        chk("quant_ready", in_ready, 0);
        if (!keep_valid) in_valid = 1'b0;
        @(negedge clock);
        chk("latency_valid", out_valid, 1);
        i = 0;
        guard = 0;
        stalls = 0;
        while (i < NT && guard < 60) begin
            chk("byte_valid", out_valid, 1);
            chk($sformatf("byte%0d", i), pixel_out, exp_q[i]);
            chk("byte_last", out_last, (i == NT - 1));
            chk("send_ready", in_ready, 0);
            if (i == 0 && stalls < stall0) begin
                rdy = 1'b0;
                stalls++;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 2) != 0);
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            @(negedge clock);
            if (rdy) i++;
            guard++;
        end
        chk("all_bytes", i, NT);
        chk("idle_valid", out_valid, 0);
        chk("idle_ready", in_ready, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        pixel_in  = '0;
        bias      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_valid", out_valid, 0);
        chk("rst_pixel", pixel_out, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", in_ready, 1);

        run_vec(180, 20, 0, 0, 0, 1'b0, 1'b0);
        run_vec(182, 20, 0, -22, 0, 1'b0, 1'b0);
        run_vec(2000, -2000, 0, 0, 0, 1'b0, 1'b0);
        run_vec(-2, 6, 0, 0, 0, 1'b0, 1'b0);
        run_vec(180, 20, 0, 0, 5, 1'b0, 1'b1);
        run_vec(32'h7fffffff, 32'h80000000, 32'h7fffffff, 32'h80000000, 0, 1'b0, 1'b0);

        // Abort after the first byte has been handed off.
        pixel_in = {32'd20, 32'd180};
        bias     = '0;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        chk("abort_byte0", pixel_out, model_q(180, 0));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("abort_byte1", pixel_out, model_q(20, 0));
        reset = 1'b1;
        @(negedge clock);
        chk("abort_valid", out_valid, 0);
        chk("abort_pixel", pixel_out, 0);
        chk("abort_ready", in_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_idle", in_ready, 1);
        chk("abort_quiet", out_valid, 0);
        run_vec(100, -100, 3, -3, 0, 1'b0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            int p0, p1, b0, b1;
            if (n % 5 == 0) begin
                p0 = int'($urandom);
                p1 = int'($urandom);
                b0 = int'($urandom);
                b1 = int'($urandom);
            end else begin
                p0 = int'($urandom_range(0, 2400)) - 1200;
                p1 = int'($urandom_range(0, 2400)) - 1200;
                b0 = int'($urandom_range(0, 64)) - 32;
                b1 = int'($urandom_range(0, 64)) - 32;
            end
            run_vec(p0, p1, b0, b1, int'($urandom_range(0, 3)), 1'b1, n[0]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
